kgp_alu_mc: RTL and testbench

KGP_ALU_MC -- requirements
Module: kgp_alu_mc

---
 rtl/kgp_alu_pkg.sv | 35 +++
 rtl/kgp_alu_iter.sv | 71 +++++++
 rtl/kgp_alu_mc.sv | 164 ++++++++++++++++
 tb/tb_kgp_alu_mc.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/kgp_alu_pkg.sv
// Shared types for the multi-cycle ALU: opcodes, FSM states and flag bit positions.
package kgp_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_MUL  = 4'h2,
        OP_DIV  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_XOR  = 4'h6,
        OP_NOT  = 4'h7,
        OP_PASA = 4'h8,
        OP_PASB = 4'h9,
        OP_SHL  = 4'hA,
        OP_SHR  = 4'hB,
        OP_SAR  = 4'hC,
        OP_ADD4 = 4'hD,
        OP_SUB4 = 4'hE,
        OP_POP  = 4'hF
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int FLAG_CARRY = 0;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_NEG   = 2;
    localparam int FLAG_OVF   = 3;
    localparam int FLAG_DIVZ  = 4;

endpackage

// File: rtl/kgp_alu_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// WIDTH steps after start; done is asserted during the final step with its result on the outputs.
module kgp_alu_iter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             hi_nonzero
);
    import kgp_alu_pkg::*;

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             active;
    logic             mode_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opnd;
    // Upper half: accumulator (MUL) or remainder (DIV); lower half: multiplier or dividend/quotient.
    logic [2*WIDTH-1:0] p;
    logic [2*WIDTH-1:0] p_n;
    logic [2*WIDTH-1:0] mul_n;
    logic [2*WIDTH-1:0] div_n;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     r_sh;
    logic [WIDTH:0]     diff;
    logic               fits;

    always_comb begin
        sum   = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, opnd} : '0);
        mul_n = {sum, p[WIDTH-1:1]};
        r_sh  = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
        diff  = r_sh - {1'b0, opnd};
        fits  = ~diff[WIDTH];
        div_n = {(fits ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0]), p[WIDTH-2:0], fits};
        p_n   = mode_q ? div_n : mul_n;
    end

    assign done       = active && (cnt == LAST);
    assign result     = p_n[WIDTH-1:0];
    assign hi_nonzero = |p_n[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
            mode_q <= 1'b0;
            cnt    <= '0;
            opnd   <= '0;
            p      <= '0;
        end else if (start) begin
            active <= 1'b1;
            mode_q <= mode;
            cnt    <= '0;
            opnd   <= mode ? b : a;
            p      <= {{WIDTH{1'b0}}, (mode ? a : b)};
        end else if (active) begin
            p   <= p_n;
            cnt <= cnt + 1'b1;
            if (done) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/kgp_alu_mc.sv
// Multi-cycle ALU: single-cycle ops answer one cycle after accept, MUL/DIV after WIDTH+1.
// One request in flight; result and flags are held in DONE until out_ready.
module kgp_alu_mc #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic [4:0]       flags
);
    import kgp_alu_pkg::*;

    localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);

    state_e           state, state_n;
    logic             start;
    logic             load_alu;
    logic             load_iter;
    logic             is_mul_q;
    logic             iter_done;
    logic [WIDTH-1:0] iter_result;
    logic             iter_hi;

    logic [WIDTH-1:0] alu_z;
    logic [4:0]       alu_flags;
    logic             alu_c;
    logic             alu_v;
    logic             alu_dz;
    logic [WIDTH-1:0] rhs;
    logic [WIDTH:0]   ext;
    logic [SHW:0]     pop;
    logic [SHW-1:0]   sh;

    kgp_alu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (op == OP_DIV),
        .a          (a),
        .b          (b),
        .done       (iter_done),
        .result     (iter_result),
        .hi_nonzero (iter_hi)
    );

    // Single-cycle datapath evaluated on the live request inputs.
    always_comb begin
        alu_z  = '0;
        alu_c  = 1'b0;
        alu_v  = 1'b0;
        alu_dz = 1'b0;
        sh     = b[SHW-1:0];
        rhs    = (op == OP_ADD || op == OP_SUB) ? b : FOUR;
        ext    = '0;
        pop    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + {{SHW{1'b0}}, a[i]};
        end
        case (op_e'(op))
            OP_ADD, OP_ADD4: begin
                ext   = {1'b0, a} + {1'b0, rhs};
                alu_z = ext[WIDTH-1:0];
                alu_c = ext[WIDTH];
                alu_v = (a[WIDTH-1] == rhs[WIDTH-1]) && (alu_z[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_SUB4: begin
                ext   = {1'b0, a} - {1'b0, rhs};
                alu_z = ext[WIDTH-1:0];
                alu_c = ext[WIDTH];
                alu_v = (a[WIDTH-1] != rhs[WIDTH-1]) && (alu_z[WIDTH-1] != a[WIDTH-1]);
            end
            OP_DIV: begin
                alu_z  = '1;
                alu_dz = 1'b1;
            end
            OP_AND:  alu_z = a & b;
            OP_OR:   alu_z = a | b;
            OP_XOR:  alu_z = a ^ b;
            OP_NOT:  alu_z = ~a;
            OP_PASA: alu_z = a;
            OP_PASB: alu_z = b;
            OP_SHL:  alu_z = a << sh;
            OP_SHR:  alu_z = a >> sh;
            OP_SAR:  alu_z = $unsigned($signed(a) >>> sh);
            OP_POP:  alu_z = {{(WIDTH-SHW-1){1'b0}}, pop};
            default: alu_z = '0;
        endcase
        alu_flags             = '0;
        alu_flags[FLAG_CARRY] = alu_c;
        alu_flags[FLAG_ZERO]  = (alu_z == '0);
        alu_flags[FLAG_NEG]   = alu_z[WIDTH-1];
        alu_flags[FLAG_OVF]   = alu_v;
        alu_flags[FLAG_DIVZ]  = alu_dz;
    end

    always_comb begin
        state_n   = state;
        start     = 1'b0;
        load_alu  = 1'b0;
        load_iter = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (op == OP_MUL || (op == OP_DIV && b != '0)) begin
                        start   = 1'b1;
                        state_n = ST_BUSY;
                    end else begin
                        load_alu = 1'b1;
                        state_n  = ST_DONE;
                    end
                end
            end
            ST_BUSY: begin
                if (iter_done) begin
                    load_iter = 1'b1;
                    state_n   = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            z        <= '0;
            flags    <= '0;
            is_mul_q <= 1'b0;
        end else begin
            state <= state_n;
            if (start) begin
                is_mul_q <= (op == OP_MUL);
            end
            if (load_alu) begin
                z     <= alu_z;
                flags <= alu_flags;
            end else if (load_iter) begin
                z                  <= iter_result;
                flags              <= '0;
                flags[FLAG_CARRY]  <= is_mul_q && iter_hi;
                flags[FLAG_ZERO]   <= (iter_result == '0);
                flags[FLAG_NEG]    <= iter_result[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_kgp_alu_mc.sv
// Directed bench for kgp_alu_mc at WIDTH=8 and WIDTH=16 with hand-computed results.
module tb_kgp_alu_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [3:0] op;
    logic [7:0] a, b, z;
    logic [4:0] flags;

    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
    logic [3:0]  w_op;
    logic [15:0] w_a, w_b, w_z;
    logic [4:0]  w_flags;

    int checks   = 0;
    int failures = 0;

    kgp_alu_mc #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .z(z), .flags(flags)
    );

    kgp_alu_mc #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .op(w_op),
        .a(w_a), .b(w_b), .out_valid(w_out_valid), .out_ready(w_out_ready), .z(w_z), .flags(w_flags)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one request on the 8-bit DUT, check latency/result, optionally stall the consumer.
    task automatic run8(input string tag, input logic [3:0] t_op, input logic [7:0] t_a,
                        input logic [7:0] t_b, input logic [7:0] ez, input logic [4:0] ef,
                        input int elat, input int hold);
        int lat;
        bit rdy_seen;
        op = t_op; a = t_a; b = t_b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 40) begin
            if (in_ready) rdy_seen = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        if (in_ready) rdy_seen = 1'b1;
        check({tag, " lat"}, lat, elat);
        check({tag, " z"}, z, ez);
        check({tag, " flags"}, flags, ef);
        check({tag, " in_ready_low"}, rdy_seen, 0);
        // A competing request during the stall must be ignored.
        in_valid = (hold > 0);
        op = 4'h0; a = 8'h01; b = 8'h01;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, " hold_vld"}, out_valid, 1);
            check({tag, " hold_z"}, {flags, z}, {ef, ez});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({tag, " idle"}, {out_valid, in_ready}, 2'b01);
    endtask

    task automatic run16(input string tag, input logic [3:0] t_op, input logic [15:0] t_a,
                         input logic [15:0] t_b, input logic [15:0] ez, input logic [4:0] ef,
                         input int elat);
        int lat;
        w_op = t_op; w_a = t_a; w_b = t_b; w_in_valid = 1'b1;
        @(posedge clk); #1;
        w_in_valid = 1'b0;
        lat = 1;
        while (!w_out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " lat"}, lat, elat);
        check({tag, " z"}, w_z, ez);
        check({tag, " flags"}, w_flags, ef);
        w_out_ready = 1'b1;
        @(posedge clk); #1;
        w_out_ready = 1'b0;
    endtask

    initial begin
        bit vld_seen;
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
        w_in_valid = 1'b0; w_out_ready = 1'b0; w_op = '0; w_a = '0; w_b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst in_ready", in_ready, 1);
        check("rst out_valid", out_valid, 0);
        check("rst z", z, 0);
        check("rst flags", flags, 0);

        //    tag        op     a      b      z      flags     lat hold
        run8("add_wrap", 4'h0, 8'hFF, 8'h01, 8'h00, 5'b00011, 1, 0);
        run8("mul",      4'h2, 8'h10, 8'h11, 8'h10, 5'b00001, 9, 0);
        run8("div",      4'h3, 8'd200, 8'd7, 8'd28, 5'b00000, 9, 0);
        run8("div0",     4'h3, 8'd5,  8'h00, 8'hFF, 5'b10100, 1, 0);
        run8("sar_bp",   4'hC, 8'h80, 8'h03, 8'hF0, 5'b00100, 1, 5);
        run8("xor",      4'h6, 8'hF0, 8'h3C, 8'hCC, 5'b00100, 1, 0);
        run8("shl0",     4'hA, 8'h5A, 8'h00, 8'h5A, 5'b00000, 1, 0);
        run8("shl_lo",   4'hA, 8'h5A, 8'h09, 8'hB4, 5'b00100, 1, 0);
        run8("shr7",     4'hB, 8'h80, 8'h07, 8'h01, 5'b00000, 1, 0);
        run8("not",      4'h7, 8'hFF, 8'h00, 8'h00, 5'b00010, 1, 0);
        run8("add4_ovf", 4'hD, 8'h7E, 8'h00, 8'h82, 5'b01100, 1, 0);
        run8("sub4_brw", 4'hE, 8'h02, 8'h00, 8'hFE, 5'b00101, 1, 0);
        run8("pass_b",   4'h9, 8'h00, 8'h80, 8'h80, 5'b00100, 1, 0);
        run8("pop",      4'hF, 8'hB5, 8'h00, 8'h05, 5'b00000, 1, 0);

        // Reset lands in cycle T+4 of a multiply.
        op = 4'h2; a = 8'h0F; b = 8'h0F; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mrst in_ready", in_ready, 1);
        check("mrst z", z, 0);
        check("mrst flags", flags, 0);
        vld_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) vld_seen = 1'b1;
            @(posedge clk); #1;
        end
        check("mrst no_result", vld_seen, 0);

        run16("sub16_ovf", 4'h1, 16'h8000, 16'h0001, 16'h7FFF, 5'b01000, 1);
        run16("pop16",     4'hF, 16'hFFFF, 16'h0000, 16'd16,   5'b00000, 1);
        run16("mul16_hi",  4'h2, 16'h0100, 16'h0100, 16'h0000, 5'b00011, 17);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
